v_mask_packer: RTL and testbench
================================

# v_mask_packer

Downstream packing stage for the vector ALU compare path. Consumes the per-beat compare flags produced by the add/min/max unit (one flag per byte lane in bits [7:0] of each result beat) and packs one bit per element into dense 64-bit mask-register words. Emits a word when 64 element bits have been collected or when the instruction's last beat arrives, for write-back to the mask destination register.

## Interface

Parameters:
- `REQ_DATA_WIDTH`, default 64: input beat width; only bits [7:0] are consumed.
- `MASK_WIDTH`, default 64: packed output word width; must be a multiple of 8.
- `SEW_WIDTH`, default 2: element-width code width.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, asynchronous and active-low.
- `in_vec`, input, REQ_DATA_WIDTH: compare result beat; bit b is the flag of byte lane b.
- `in_valid`, input, 1: `in_vec` is valid this cycle. There is no backpressure.
- `in_sew`, input, SEW_WIDTH: element width code. 0 = 8 bit, 1 = 16 bit, 2 = 32 bit, 3 = 64 bit.
- `in_last`, input, 1: final beat of the instruction; qualified by `in_valid`.
- `out_mask`, output, MASK_WIDTH: packed mask word.
- `out_count`, output, $clog2(MASK_WIDTH)+1: number of valid element bits in `out_mask`, from 1 to 64.
- `out_valid`, output, 1: single-cycle pulse qualifying `out_mask` and `out_count`.

## Operation

- **Elements per beat:** n = 8 >> sew, giving 8, 4, 2 or 1.
- **Flag source:** the flag for element k is taken from `in_vec[(k+1)*(1<<sew) - 1]`, which is the element's most significant byte lane. All other lanes are ignored.
- **State registers:**
  - `acc`, MASK_WIDTH bits: the word being assembled.
  - `ptr`, 7 bits: the next free bit position.
  - `sew_q`: the latched element width.
  - A flag recording whether a word is in progress (ptr ≠ 0 or a beat has been taken).
- **SEW latching:** `in_sew` is sampled on the first beat of each word (ptr == 0) into `sew_q`. Later beats of the same word use `sew_q`; `in_sew` is ignored for them.
- **Each accepted beat:** the n flag bits are written to `acc[ptr +: n]`, and `ptr` advances to ptr + n. `ptr` is always a multiple of n, so a beat never straddles a word boundary.
- **Emit condition:** a word is emitted when ptr + n == MASK_WIDTH, or when `in_last` is high on an accepted beat.
  - `out_mask` = the merged word with the tail bits (positions ≥ ptr + n) filled per the Configuration section.
  - `out_count` = ptr + n.
  - `acc`, `ptr` and the in-progress flag are cleared in the same cycle, so the next beat starts a fresh word.
- **Both conditions on the same beat:** exactly one word is emitted.
- **Idle cycles:** `in_valid` low holds all state. Gaps between beats are legal.
- **Flag bits above [7:0]** of `in_vec` are ignored.

## Timing

- **Latency:** the emitting beat at cycle t produces `out_valid` at cycle t+1. All outputs are registered.
- **Throughput:** one beat per cycle, sustained. A word emitted at t+1 does not stall a beat arriving at t+1.
- **Reset values:** `out_mask` = 0, `out_count` = 0, `out_valid` = 0, `acc` = 0, `ptr` = 0.
- **Output hold:** `out_mask` and `out_count` hold their last value while `out_valid` is 0.
- **Reset mid-word:** the partial word is discarded with no emission. The first beat after `rst` deasserts starts a new word and re-samples `in_sew`.
- **SEW change mid-word:** `sew_q` is used until the word emits. The new `in_sew` takes effect on the beat after the emit.

## Configuration

- Macro: `VMASK_PACK_TAIL_ONES_EN`.
- **Defined:** tail bits of an emitted word (positions ≥ `out_count`) are driven to 1, per tail-agnostic all-ones policy.
- **Undefined:** tail bits are driven to 0.
- In both cases, a full word (`out_count` = 64) is unaffected.

## Test plan

1. SEW8, 8 consecutive beats with `in_vec[7:0]` = 0xA5, `in_last` on beat 8: one pulse one cycle after beat 8, `out_mask` = 0xA5A5A5A5A5A5A5A5, `out_count` = 64. No pulse earlier.
2. SEW64, 3 beats with `in_vec[7:0]` = 0x80, 0x00, 0x80, `in_last` on beat 3:
   - `out_mask` = 0x5, `out_count` = 3 when the macro is undefined.
   - `out_mask` = 0xFFFFFFFFFFFFFFFD with the macro defined.
3. SEW16, 20 beats of 0xAA, `in_last` on beat 20: first pulse after beat 16 with 0xFFFF_FFFF_FFFF_FFFF / 64. Second pulse after beat 20 with 0xFFFF / 16 (macro undefined).
4. SEW32, beats 0x80, 0x08, with `in_valid` low for 3 cycles between them, `in_sew` switched to 0 on beat 2, `in_last` on beat 2: `out_mask` = 0x6, `out_count` = 4. This checks that `sew_q` is held.
5. SEW8, 5 beats of 0xFF, `rst` pulsed low, then SEW8 one beat 0x01 with `in_last`: no pulse for the discarded beats, then `out_mask` = 0x01, `out_count` = 8. All outputs are 0 during reset.
6. SEW8, 8 beats 0xFF with `in_last` on beat 8, immediately followed by beat 0x3C with `in_last`: back-to-back pulses of 0xFF…FF / 64, then 0x3C / 8.

Source files
------------

// File: rtl/v_mask_packer.sv
// Packs per-element compare flags from vector ALU result beats into dense mask words.
// Optional `VMASK_PACK_TAIL_ONES_EN fills unused tail bits of an emitted word with ones instead of zeros.
module v_mask_packer #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int MASK_WIDTH     = 64,
    parameter int SEW_WIDTH      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_DATA_WIDTH-1:0]     in_vec,
    input  logic                          in_valid,
    input  logic [SEW_WIDTH-1:0]          in_sew,
    input  logic                          in_last,
    output logic [MASK_WIDTH-1:0]         out_mask,
    output logic [$clog2(MASK_WIDTH):0]   out_count,
    output logic                          out_valid
);

    localparam int PTR_W = $clog2(MASK_WIDTH) + 1;

    logic [MASK_WIDTH-1:0] r_acc;
    logic [PTR_W-1:0]      r_ptr;
    logic [SEW_WIDTH-1:0]  r_sew;
    logic                  r_busy;

    logic [SEW_WIDTH-1:0]  w_sew;
    logic [7:0]            w_flags;
    logic [PTR_W-1:0]      w_n;
    logic [PTR_W-1:0]      w_end;
    logic [MASK_WIDTH-1:0] w_merged;
    logic [MASK_WIDTH-1:0] w_live;
    logic [MASK_WIDTH-1:0] w_out;
    logic                  w_emit;
    logic                  w_unused;

    // Element width is fixed by the first beat of a word.
    assign w_sew = r_busy ? r_sew : in_sew;

    // Each element's flag is its most significant byte lane.
    always_comb begin
        w_flags = '0;
        w_n     = '0;
        case (w_sew[1:0])
            2'd0: begin
                w_flags = in_vec[7:0];
                w_n     = PTR_W'(8);
            end
            2'd1: begin
                w_flags = {4'b0, in_vec[7], in_vec[5], in_vec[3], in_vec[1]};
                w_n     = PTR_W'(4);
            end
            2'd2: begin
                w_flags = {6'b0, in_vec[7], in_vec[3]};
                w_n     = PTR_W'(2);
            end
            default: begin
                w_flags = {7'b0, in_vec[7]};
                w_n     = PTR_W'(1);
            end
        endcase
    end

    assign w_end    = r_ptr + w_n;
    assign w_merged = r_acc | (MASK_WIDTH'(w_flags) << r_ptr);
    assign w_emit   = (w_end == PTR_W'(MASK_WIDTH)) || in_last;
    // Shifting by the full width yields zero, so a full word keeps every bit.
    assign w_live   = ~({MASK_WIDTH{1'b1}} << w_end);

`ifdef VMASK_PACK_TAIL_ONES_EN
    assign w_out = w_merged | ~w_live;
`else
    assign w_out = w_merged & w_live;
`endif

    assign w_unused = ^in_vec[REQ_DATA_WIDTH-1:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_ptr     <= '0;
            r_sew     <= '0;
            r_busy    <= 1'b0;
            out_mask  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                r_sew <= w_sew;
                if (w_emit) begin
                    r_acc     <= '0;
                    r_ptr     <= '0;
                    r_busy    <= 1'b0;
                    out_mask  <= w_out;
                    out_count <= w_end;
                    out_valid <= 1'b1;
                end else begin
                    r_acc  <= w_merged;
                    r_ptr  <= w_end;
                    r_busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_v_mask_packer.sv
// Directed-vector bench for v_mask_packer; expected words are hand-computed constants.
module tb_v_mask_packer;

    logic        clk;
    logic        rst;
    logic [63:0] in_vec;
    logic        in_valid;
    logic [1:0]  in_sew;
    logic        in_last;
    logic [63:0] out_mask;
    logic [6:0]  out_count;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef VMASK_PACK_TAIL_ONES_EN
    localparam bit TAIL1 = 1'b1;
`else
    localparam bit TAIL1 = 1'b0;
`endif

    v_mask_packer dut (
        .clk      (clk),
        .rst      (rst),
        .in_vec   (in_vec),
        .in_valid (in_valid),
        .in_sew   (in_sew),
        .in_last  (in_last),
        .out_mask (out_mask),
        .out_count(out_count),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one beat at a negedge, then check the outputs one edge later.
    task automatic beat(input string tag, input logic [7:0] v, input logic [1:0] s,
                        input logic l, input logic pulse,
                        input logic [63:0] emask, input logic [6:0] ecnt);
        in_vec   = {56'hDEAD_BEEF_0000_00, v};
        in_sew   = s;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        chk({tag, ".valid"}, 64'(out_valid), 64'(pulse));
        if (pulse) begin
            chk({tag, ".mask"}, out_mask, emask);
            chk({tag, ".count"}, 64'(out_count), 64'(ecnt));
        end
    endtask

    task automatic idle(input string tag, input int cycles);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, ".idle"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b0; in_vec = '0; in_valid = 1'b0; in_sew = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.mask", out_mask, 64'd0);
        chk("rst.count", 64'(out_count), 64'd0);
        chk("rst.valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        idle("t0", 1);

        // 1: SEW8 full word
        for (int i = 1; i <= 8; i++)
            beat("t1", 8'hA5, 2'd0, i == 8, i == 8, 64'hA5A5_A5A5_A5A5_A5A5, 7'd64);
        idle("t1", 1);
        chk("t1.hold_mask", out_mask, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("t1.hold_count", 64'(out_count), 64'd64);

        // 2: SEW64 partial word
        beat("t2", 8'h80, 2'd3, 1'b0, 1'b0, 64'd0, 7'd0);
        beat("t2", 8'h00, 2'd3, 1'b0, 1'b0, 64'd0, 7'd0);
        beat("t2", 8'h80, 2'd3, 1'b1, 1'b1,
             TAIL1 ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h5, 7'd3);
        idle("t2", 2);

        // 3: SEW16 crosses a word boundary
        for (int i = 1; i <= 20; i++)
            beat("t3", 8'hAA, 2'd1, i == 20, (i == 16) || (i == 20),
                 (i == 16 || TAIL1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF,
                 (i == 16) ? 7'd64 : 7'd16);
        idle("t3", 1);

        // 4: SEW held across gap and in_sew change
        beat("t4", 8'h80, 2'd2, 1'b0, 1'b0, 64'd0, 7'd0);
        idle("t4", 3);
        beat("t4", 8'h08, 2'd0, 1'b1, 1'b1,
             TAIL1 ? 64'hFFFF_FFFF_FFFF_FFF6 : 64'h6, 7'd4);
        idle("t4", 1);

        // 5: reset discards a partial word
        for (int i = 1; i <= 5; i++)
            beat("t5", 8'hFF, 2'd0, 1'b0, 1'b0, 64'd0, 7'd0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t5.rst_mask", out_mask, 64'd0);
        chk("t5.rst_count", 64'(out_count), 64'd0);
        chk("t5.rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle("t5", 1);
        beat("t5", 8'h01, 2'd0, 1'b1, 1'b1,
             TAIL1 ? 64'hFFFF_FFFF_FFFF_FF01 : 64'h01, 7'd8);
        idle("t5", 1);

        // 6: back-to-back emits
        for (int i = 1; i <= 8; i++)
            beat("t6", 8'hFF, 2'd0, i == 8, i == 8, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
        beat("t6b", 8'h3C, 2'd0, 1'b1, 1'b1,
             TAIL1 ? 64'hFFFF_FFFF_FFFF_FF3C : 64'h3C, 7'd8);
        idle("t6", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
